// File: rtl/parser_ingress_arbiter.sv
// rtl/parser_ingress_arbiter.sv - frame-level round-robin arbiter feeding the byte-wide packet parser
//
// Purpose: shares one parser input among N_PORTS byte streams. A port is granted
// for a whole frame, so the parser never sees interleaved bytes. Frames longer
// than MAX_FRAME_BYTES are cut: the last allowed beat carries tlast and the rest
// of the source frame is drained and dropped. GAP_CYCLES idle cycles follow
// every frame end, so the parser always returns to idle between frames.
//
// Ports:
//   aclk, areset        clock, asynchronous active-high reset
//   s_axis_*            packed per-port ingress streams (port i at [i*DATA_W +: DATA_W])
//   m_axis_*            stream to the parser
//   grant_id            current or last granted port
//   busy                high while a frame, drain or gap is in progress
//   timeout_pulse       one-cycle pulse after a frame is force-terminated
`timescale 1ns/1ps
module parser_ingress_arbiter #(
  parameter int N_PORTS         = 4,
  parameter int DATA_W          = 8,
  parameter int MAX_FRAME_BYTES = 1530,
  parameter int GAP_CYCLES      = 1
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [N_PORTS*DATA_W-1:0]  s_axis_tdata,
  input  logic [N_PORTS-1:0]         s_axis_tvalid,
  input  logic [N_PORTS-1:0]         s_axis_tlast,
  output logic [N_PORTS-1:0]         s_axis_tready,
  output logic [DATA_W-1:0]          m_axis_tdata,
  output logic                       m_axis_tvalid,
  output logic                       m_axis_tlast,
  input  logic                       m_axis_tready,
  output logic [$clog2(N_PORTS)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_pulse
);
  localparam int ID_W  = $clog2(N_PORTS);
  localparam int CNT_W = $clog2(MAX_FRAME_BYTES + 1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DRAIN, S_GAP} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ID_W-1:0]   r_grant_id;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   w_winner;
  logic [ID_W-1:0]   w_rr_next;
  logic              w_found;
  logic [CNT_W-1:0]  r_beat_cnt;
  logic [3:0]        r_gap_cnt;
  logic              r_timeout;
  logic              w_timeout;
  logic              w_grant_start;
  logic              w_accept;
  logic              w_force_last;
  logic [DATA_W-1:0] w_src_data;
  logic              w_src_valid;
  logic              w_src_last;

  assign w_src_data  = s_axis_tdata[int'(r_grant_id)*DATA_W +: DATA_W];
  assign w_src_valid = s_axis_tvalid[r_grant_id];
  assign w_src_last  = s_axis_tlast[r_grant_id];

  // First requester at or after r_rr_ptr, wrapping modulo N_PORTS.
  always_comb begin
    logic [ID_W-1:0] w_idx;
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      w_idx = ID_W'((int'(r_rr_ptr) + k) % N_PORTS);
      if (!w_found && s_axis_tvalid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  assign w_rr_next = (w_winner == ID_W'(N_PORTS - 1)) ? '0 : w_winner + 1'b1;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_grant_start = 1'b0;
    w_timeout     = 1'b0;
    w_accept      = 1'b0;
    w_force_last  = 1'b0;
    s_axis_tready = '0;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_next  = S_GRANT;
          w_grant_start = 1'b1;
        end
      end
      S_GRANT: begin
        w_force_last              = (r_beat_cnt == CNT_W'(MAX_FRAME_BYTES - 1));
        m_axis_tdata              = w_src_data;
        m_axis_tvalid             = w_src_valid;
        m_axis_tlast              = w_src_last | w_force_last;
        s_axis_tready[r_grant_id] = m_axis_tready;
        w_accept                  = w_src_valid & m_axis_tready;
        // A source tlast on the length-limit beat is a normal end, not a timeout.
        if (w_accept && w_src_last) begin
          w_state_next = S_GAP;
        end else if (w_accept && w_force_last) begin
          w_state_next = S_DRAIN;
          w_timeout    = 1'b1;
        end
      end
      S_DRAIN: begin
        s_axis_tready[r_grant_id] = 1'b1;
        if (w_src_valid && w_src_last) begin
          w_state_next = S_GAP;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == 4'(GAP_CYCLES - 1)) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
      r_gap_cnt  <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= w_timeout;
      if (w_grant_start) begin
        r_grant_id <= w_winner;
        r_rr_ptr   <= w_rr_next;
        r_beat_cnt <= '0;
      end else if (w_accept && (r_beat_cnt != CNT_W'(MAX_FRAME_BYTES))) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
      // Held at zero outside the gap, so it starts from zero on every gap entry.
      if (r_state == S_GAP) begin
        r_gap_cnt <= r_gap_cnt + 1'b1;
      end else begin
        r_gap_cnt <= '0;
      end
    end
  end

  assign grant_id      = r_grant_id;
  assign busy          = (r_state != S_IDLE);
  assign timeout_pulse = r_timeout;

endmodule

// File: tb/tb_parser_ingress_arbiter.sv
// tb/tb_parser_ingress_arbiter.sv - scoreboard bench for parser_ingress_arbiter
`timescale 1ns/1ps
module tb_parser_ingress_arbiter;
  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int MAXB = 16;
  localparam int GAP  = 2;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic [N*DW-1:0] s_tdata;
  logic [N-1:0]  s_tvalid, s_tlast, s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, m_tlast, m_tready;
  logic [1:0]    grant_id;
  logic          busy, timeout_pulse;

  parser_ingress_arbiter #(
    .N_PORTS(N), .DATA_W(DW), .MAX_FRAME_BYTES(MAXB), .GAP_CYCLES(GAP)
  ) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
    .m_axis_tready(m_tready),
    .grant_id(grant_id), .busy(busy), .timeout_pulse(timeout_pulse)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", name, act, req, cyc);
    end
  endtask

  // Source side: per-port queues of {last, data}
  logic [8:0] src_q [N][$];
  logic [N-1:0] acc;
  logic [N-1:0] mid;
  int tready_mode = 0;
  bit bubbles = 1'b0;

  initial begin
    s_tdata = '0; s_tvalid = '0; s_tlast = '0; m_tready = 1'b0; acc = '0; mid = '0;
    forever begin
      @(negedge aclk);
      acc = s_tvalid & s_tready;
      @(posedge aclk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (areset) begin
          mid[i] = 1'b0;
        end else if (acc[i] && src_q[i].size() > 0) begin
          mid[i] = !src_q[i][0][8];
          void'(src_q[i].pop_front());
        end
        if (src_q[i].size() > 0) begin
          s_tdata[i*DW +: DW] = src_q[i][0][7:0];
          s_tlast[i]  = src_q[i][0][8];
          s_tvalid[i] = !(bubbles && mid[i] && ($urandom_range(0, 3) == 0));
        end else begin
          s_tdata[i*DW +: DW] = '0;
          s_tlast[i]  = 1'b0;
          s_tvalid[i] = 1'b0;
        end
      end
      case (tready_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = !m_tready;
        default: m_tready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Reference model: frames per port, round-robin over ports with pending frames
  typedef struct {
    logic [7:0] data;
    logic       last;
    int         port;
    logic       forced;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] pend_bytes [N][$];
  int         pend_len [N][$];
  int         model_ptr = 0;
  logic [7:0] tmp_bytes[$];

  task automatic add_frame(input int port);
    logic lst;
    pend_len[port].push_back(tmp_bytes.size());
    foreach (tmp_bytes[b]) begin
      lst = (b == tmp_bytes.size() - 1);
      pend_bytes[port].push_back(tmp_bytes[b]);
      src_q[port].push_back({lst, tmp_bytes[b]});
    end
    tmp_bytes.delete();
  endtask

  task automatic rand_frame(input int port, input int len);
    for (int b = 0; b < len; b++) tmp_bytes.push_back(8'($urandom_range(0, 255)));
    add_frame(port);
  endtask

  task automatic build_expected();
    int p;
    int len;
    beat_t e;
    logic [7:0] d;
    while (1) begin
      p = -1;
      for (int k = 0; k < N; k++) begin
        if (p < 0 && pend_len[(model_ptr + k) % N].size() > 0) p = (model_ptr + k) % N;
      end
      if (p < 0) break;
      model_ptr = (p + 1) % N;
      len = pend_len[p].pop_front();
      for (int b = 0; b < len; b++) begin
        d = pend_bytes[p].pop_front();
        if (b < MAXB) begin
          e.data   = d;
          e.last   = (b == len - 1) || (b == MAXB - 1);
          e.port   = p;
          e.forced = (b == MAXB - 1) && (len > MAXB);
          exp_q.push_back(e);
        end
      end
    end
  endtask

  // Monitor
  int   lat_target = -1;
  logic pulse_pend = 1'b0;
  int   gap_k = 0;

  initial begin
    beat_t e;
    forever begin
      @(negedge aclk);
      if (areset) begin
        pulse_pend = 1'b0;
        gap_k = 0;
      end else begin
        check("timeout_pulse", timeout_pulse, pulse_pend);
        pulse_pend = 1'b0;
        if (gap_k > 0) begin
          check("busy_after_frame", busy, (gap_k <= GAP));
          gap_k = (gap_k == GAP + 1) ? 0 : gap_k + 1;
        end
        if (!busy) begin
          check("idle_s_tready", s_tready, 0);
          check("idle_m_tvalid", m_tvalid, 0);
          check("idle_m_tlast", m_tlast, 0);
        end
        if (m_tvalid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", m_tvalid, 0);
          end else begin
            check("s_tready_mirror", s_tready, m_tready ? (1 << exp_q[0].port) : 0);
            if (m_tready) begin
              e = exp_q.pop_front();
              check("m_tdata", m_tdata, e.data);
              check("m_tlast", m_tlast, e.last);
              check("grant_id", grant_id, e.port);
              if (lat_target >= 0) begin
                check("first_beat_cycle", cyc, lat_target);
                lat_target = -1;
              end
              if (e.last && !e.forced) gap_k = 1;
              pulse_pend = e.forced;
            end
          end
        end
      end
    end
  end

  task automatic start_phase(input bit chk_lat);
    build_expected();
    if (chk_lat) lat_target = cyc + 2;
  endtask

  task automatic wait_done(input string name);
    int left;
    for (int t = 0; t < 3000; t++) begin
      @(negedge aclk);
      left = 0;
      for (int i = 0; i < N; i++) left += src_q[i].size();
      if (exp_q.size() == 0 && left == 0 && !busy) break;
    end
    left = 0;
    for (int i = 0; i < N; i++) left += src_q[i].size();
    check({name, "_expected_left"}, exp_q.size(), 0);
    check({name, "_source_left"}, left, 0);
    exp_q.delete();
    for (int i = 0; i < N; i++) src_q[i].delete();
    repeat (3) @(negedge aclk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_tready"}, s_tready, 0);
    check({tag, "_m_tvalid"}, m_tvalid, 0);
    check({tag, "_m_tlast"}, m_tlast, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_grant_id"}, grant_id, 0);
    check({tag, "_timeout_pulse"}, timeout_pulse, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int left;
    areset = 1'b1;
    repeat (3) @(negedge aclk);
    check_reset_outputs("reset");
    areset = 1'b0;
    repeat (2) @(negedge aclk);

    // Contention: every port holds two 4-byte frames
    for (int f = 0; f < 2; f++)
      for (int p = 0; p < N; p++) begin
        for (int b = 0; b < 4; b++) tmp_bytes.push_back(8'(p * 16 + f * 4 + b));
        add_frame(p);
      end
    start_phase(1'b1);
    wait_done("contention");

    // Single port: preamble, SFD, header bytes ending in ethertype 0x0800
    for (int b = 0; b < 7; b++) tmp_bytes.push_back(8'h55);
    tmp_bytes.push_back(8'hD5);
    for (int b = 1; b <= 6; b++) tmp_bytes.push_back(8'(b));
    tmp_bytes.push_back(8'h08);
    tmp_bytes.push_back(8'h00);
    add_frame(0);
    start_phase(1'b1);
    wait_done("single_port");

    // Backpressure: toggling parser ready
    tready_mode = 1;
    rand_frame(2, 10);
    start_phase(1'b0);
    wait_done("backpressure");
    tready_mode = 0;

    // Timeout: 20-byte frame against a 16-beat limit
    rand_frame(1, 20);
    start_phase(1'b1);
    wait_done("timeout");

    // Exact-length frame
    rand_frame(3, MAXB);
    start_phase(1'b1);
    wait_done("exact_length");

    // Randomized traffic
    tready_mode = 2;
    bubbles = 1'b1;
    for (int r = 0; r < 8; r++) begin
      for (int p = 0; p < N; p++) begin
        int nf;
        nf = $urandom_range(0, 2);
        for (int f = 0; f < nf; f++) rand_frame(p, $urandom_range(1, 24));
      end
      start_phase(1'b0);
      wait_done("random");
    end
    tready_mode = 0;
    bubbles = 1'b0;

    // Reset at beat 5 of a port-2 frame
    rand_frame(2, 10);
    start_phase(1'b0);
    for (int t = 0; t < 200; t++) begin
      @(negedge aclk);
      if (src_q[2].size() <= 6) break;
    end
    check("reset_mid_frame_reached", src_q[2].size(), 6);
    #2;
    areset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    @(posedge aclk);
    #3;
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      pend_bytes[i].delete();
      pend_len[i].delete();
    end
    exp_q.delete();
    model_ptr = 0;
    pulse_pend = 1'b0;
    gap_k = 0;
    @(negedge aclk);
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    rand_frame(3, 6);
    start_phase(1'b1);
    wait_done("after_reset");

    left = 0;
    for (int i = 0; i < N; i++) left += src_q[i].size();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
